// File: rtl/hamming_secded_engine.sv
// hamming_secded_engine: walks NUM_WORDS SECDED words at SRC_BASE, writes corrected 11-bit data plus a double-error flag to DST_BASE
// Ports: CLK clock; reset sync active-low; start/done req/ack handshake;
//        mem_addr/mem_rd_data/mem_wr_en/mem_wr_data byte-wide data-memory port;
//        single_cnt/double_cnt saturating error counts for the current run.
module hamming_secded_engine #(
    parameter int SRC_BASE  = 64,
    parameter int DST_BASE  = 94,
    parameter int NUM_WORDS = 15,
    parameter int AW        = 8
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data,
    output logic [6:0]    single_cnt,
    output logic [6:0]    double_cnt
);
    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, DECODE, WR_LO, WR_HI, DONE} state_t;
    state_t state;
    logic [5:0] i;
    logic [7:0] lo, hi;
    logic [15:0] w, wc, res, r;
    logic [3:0] syn;
    logic par, dbl;
    assign w = {hi, lo};
    // syn names the flipped Hamming position; odd overall parity means exactly one flip
    always_comb begin
        syn = '0;
        for (int k = 1; k < 16; k++) syn = syn ^ (w[k] ? k[3:0] : 4'd0);
        par = ^w;
        dbl = !par && syn != 4'd0;
        wc = w;
        if (par && syn != 4'd0) wc[syn] = ~w[syn];
        res = {dbl, 4'b0, wc[15:9], wc[7:5], wc[3]};
    end
    always_comb begin
        mem_addr = state == RD_LO ? AW'(SRC_BASE) + AW'({i, 1'b0}) :
                   state == RD_HI ? AW'(SRC_BASE) + AW'({i, 1'b1}) :
                   state == WR_LO ? AW'(DST_BASE) + AW'({i, 1'b0}) :
                   state == WR_HI ? AW'(DST_BASE) + AW'({i, 1'b1}) : '0;
        mem_wr_en = state == WR_LO || state == WR_HI;
        mem_wr_data = state == WR_HI ? r[15:8] : r[7:0];
    end
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state <= IDLE;
            done <= 1'b0;
            i <= '0;
            single_cnt <= '0;
            double_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    i <= '0;
                    single_cnt <= '0;
                    double_cnt <= '0;
                    done <= 1'b0;
                    state <= RD_LO;
                end
                RD_LO: begin
                    lo <= mem_rd_data;
                    state <= RD_HI;
                end
                RD_HI: begin
                    hi <= mem_rd_data;
                    state <= DECODE;
                end
                DECODE: begin
                    r <= res;
                    if (par && single_cnt != 7'd127) single_cnt <= single_cnt + 7'd1;
                    if (dbl && double_cnt != 7'd127) double_cnt <= double_cnt + 7'd1;
                    state <= WR_LO;
                end
                WR_LO: state <= WR_HI;
                WR_HI: if (i == 6'(NUM_WORDS - 1)) state <= DONE;
                else begin
                    i <= i + 6'd1;
                    state <= RD_LO;
                end
                DONE: begin
                    done <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
